serial_shift_tx: RTL and testbench

Parametrised serial transmitter: accepts DATA_W-bit words over a valid/ready handshake into a small input FIFO and shifts each word out one bit per clock. Bit order (LSB- or MSB-first) is selectable. Consecutive words go out back-to-back with no idle cycle. It replaces the fixed 10-bit, LSB-only, unbuffered transmitter in the detector datapath and feeds the serial sequence checker downstream.

---
 rtl/serial_tx_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 92 +++++++++
 rtl/serial_shift_tx.sv | 155 +++++++++++++++
 tb/tb_serial_shift_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg
// Shared definitions for the serial transmitter slice:
//   - txState_t  : transmitter FSM states (IDLE, SHIFT)
//   - cntWidth() : bit-counter width for a given word width
//   - lvlWidth() : FIFO occupancy width for a given depth
//   - paramsLegal(): elaboration-time legality check of DATA_W / DEPTH
package serial_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } txState_t;

    // The bit counter must reach DATA_W-1, so $clog2(DATA_W) bits suffice.
    function automatic int cntWidth(input int dataW);
        return (dataW < 2) ? 1 : $clog2(dataW);
    endfunction

    // Occupancy runs 0..DEPTH inclusive, hence the +1.
    function automatic int lvlWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Word width 2..64, depth a power of two of at least 2.
    function automatic bit paramsLegal(input int dataW, input int depth);
        return (dataW >= 2) && (dataW <= 64) && (depth >= 2) &&
               ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Register-array FIFO with synchronous clear and occupancy output.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_clr   : synchronous clear, beats push and pop
//   i_push  : write i_data at the tail (ignored when full)
//   i_data  : word to write
//   i_pop   : drop the head entry (ignored when empty)
//   o_data  : current head entry
//   o_full  : DEPTH entries held
//   o_empty : no entries held
//   o_level : current occupancy
module sync_fifo
    import serial_tx_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4,
    localparam int LVL_W = lvlWidth(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [LVL_W-1:0]  o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q;
    logic [PTR_W-1:0]  rdPtr_q;
    logic [LVL_W-1:0]  level_q;
    logic              doPush;
    logic              doPop;

    // Qualify the requests: a full FIFO never takes a word even if the head
    // is popped in the same cycle, and clear overrides both directions.
    assign doPush = i_push & ~o_full  & ~i_clr;
    assign doPop  = i_pop  & ~o_empty & ~i_clr;

    // Storage needs no reset; only entries below the occupancy are ever read.
    always_ff @(posedge i_clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else if (i_clr) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
        end
    end

    // Occupancy moves only when exactly one of push/pop happens.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level_q <= '0;
        end else if (i_clr) begin
            level_q <= '0;
        end else begin
            case ({doPush, doPop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign o_data  = mem_q[rdPtr_q];
    assign o_full  = (level_q == LVL_W'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;

endmodule

// File: rtl/serial_shift_tx.sv
// serial_shift_tx
// Buffered serial transmitter: words enter a small FIFO over valid/ready and
// leave one bit per clock, back-to-back, LSB- or MSB-first.
// Ports:
//   i_clk       : clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_clr       : synchronous clear; empties FIFO, aborts the current frame
//   i_valid     : input word valid
//   o_ready     : FIFO can accept a word (low during and just after reset)
//   i_data      : input word
//   o_seq_bit   : serial data, 0 outside frames
//   o_bit_valid : o_seq_bit carries a frame bit
//   o_first     : first bit of a frame
//   o_tx_done   : last bit of a frame
//   o_busy      : frame in flight
//   o_level     : FIFO occupancy
module serial_shift_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int DEPTH     = 4,
    parameter bit LSB_FIRST = 1'b1,
    localparam int LVL_W    = lvlWidth(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_seq_bit,
    output logic              o_bit_valid,
    output logic              o_first,
    output logic              o_tx_done,
    output logic              o_busy,
    output logic [LVL_W-1:0]  o_level
);

    localparam int              CNT_W = cntWidth(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    if (!paramsLegal(DATA_W, DEPTH)) begin : gBadParams
        $error("serial_shift_tx: DATA_W must be 2..64 and DEPTH a power of 2 >= 2");
    end

    txState_t          state_q;
    txState_t          state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic              readyEn_q;

    logic              fifoPush;
    logic              fifoPop;
    logic [DATA_W-1:0] fifoData;
    logic              fifoFull;
    logic              fifoEmpty;

    // Ready is registered-only: it waits one edge after reset release and
    // otherwise just reflects the FIFO not being full.
    assign o_ready  = readyEn_q & ~fifoFull;
    assign fifoPush = i_valid & o_ready;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) uFifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr),
        .i_push  (fifoPush),
        .i_data  (i_data),
        .i_pop   (fifoPop),
        .o_data  (fifoData),
        .o_full  (fifoFull),
        .o_empty (fifoEmpty),
        .o_level (o_level)
    );

    // Holds o_ready low for the first cycle after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            readyEn_q <= 1'b0;
        end else begin
            readyEn_q <= 1'b1;
        end
    end

    // FSM next state. Loading the head is the FIFO pop; on the last bit a
    // waiting word is loaded straight away so frames run back-to-back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        fifoPop = 1'b0;
        if (i_clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifoEmpty) begin
                        shreg_d = fifoData;
                        cnt_d   = '0;
                        state_d = SHIFT;
                        fifoPop = 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (!fifoEmpty) begin
                            shreg_d = fifoData;
                            fifoPop = 1'b1;
                        end else begin
                            shreg_d = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            endcase
        end
    end

    // FSM, counter and shift register state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Outputs decode registered state only, so no input reaches an output.
    assign o_busy      = (state_q == SHIFT);
    assign o_bit_valid = o_busy;
    assign o_first     = o_busy & (cnt_q == '0);
    assign o_tx_done   = o_busy & (cnt_q == LAST);
    assign o_seq_bit   = o_busy & (LSB_FIRST ? shreg_q[0] : shreg_q[DATA_W-1]);

endmodule

// File: tb/tb_serial_shift_tx.sv
// tb_serial_shift_tx
// Drives an LSB-first and an MSB-first transmitter with identical stimulus
// and compares both against a queue-based model of the word stream.
module tb_serial_shift_tx;

    localparam int DATA_W = 10;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic              clock;
    logic              rstN;
    logic              iClr;
    logic              iValid;
    logic [DATA_W-1:0] iData;

    logic              readyL, seqL, bvL, firstL, doneL, busyL;
    logic [LVL_W-1:0]  levelL;
    logic              readyM, seqM, bvM, firstM, doneM, busyM;
    logic [LVL_W-1:0]  levelM;

    int checks;
    int errors;

    logic [DATA_W-1:0] mQueue[$];
    logic [DATA_W-1:0] mWord;
    bit                mBusy;
    bit                mReadyEn;
    int                mIdx;

    serial_shift_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LSB_FIRST(1'b1)) dutL (
        .i_clk (clock), .i_rst_n (rstN), .i_clr (iClr), .i_valid (iValid),
        .o_ready (readyL), .i_data (iData), .o_seq_bit (seqL),
        .o_bit_valid (bvL), .o_first (firstL), .o_tx_done (doneL),
        .o_busy (busyL), .o_level (levelL)
    );

    serial_shift_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LSB_FIRST(1'b0)) dutM (
        .i_clk (clock), .i_rst_n (rstN), .i_clr (iClr), .i_valid (iValid),
        .o_ready (readyM), .i_data (iData), .o_seq_bit (seqM),
        .o_bit_valid (bvM), .o_first (firstM), .o_tx_done (doneM),
        .o_busy (busyM), .o_level (levelM)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Model: words leave the queue in order; each occupies DATA_W cycles,
    // and a new word starts the cycle after the previous word's last bit.
    task automatic modelReset();
        mQueue.delete();
        mBusy    = 1'b0;
        mIdx     = 0;
        mWord    = '0;
        mReadyEn = 1'b0;
    endtask

    task automatic modelStep(input logic v, input logic [DATA_W-1:0] d, input logic c);
        bit accept;
        if (c) begin
            mQueue.delete();
            mBusy = 1'b0;
            mIdx  = 0;
        end else begin
            accept = v && mReadyEn && (mQueue.size() < DEPTH);
            if (mBusy && mIdx < DATA_W - 1) begin
                mIdx++;
            end else if (mQueue.size() > 0) begin
                mWord = mQueue.pop_front();
                mBusy = 1'b1;
                mIdx  = 0;
            end else begin
                mBusy = 1'b0;
                mIdx  = 0;
            end
            if (accept) mQueue.push_back(d);
        end
        mReadyEn = 1'b1;
    endtask

    task automatic compareAll();
        logic expReady;
        logic expFirst;
        logic expDone;
        logic expL;
        logic expM;
        expReady = mReadyEn && (mQueue.size() < DEPTH);
        expFirst = mBusy && (mIdx == 0);
        expDone  = mBusy && (mIdx == DATA_W - 1);
        expL     = mBusy ? mWord[mIdx] : 1'b0;
        expM     = mBusy ? mWord[DATA_W-1-mIdx] : 1'b0;
        checkOutput("L.ready",  64'(readyL), 64'(expReady));
        checkOutput("L.seqBit", 64'(seqL),   64'(expL));
        checkOutput("L.bitVld", 64'(bvL),    64'(mBusy));
        checkOutput("L.first",  64'(firstL), 64'(expFirst));
        checkOutput("L.done",   64'(doneL),  64'(expDone));
        checkOutput("L.busy",   64'(busyL),  64'(mBusy));
        checkOutput("L.level",  64'(levelL), 64'(mQueue.size()));
        checkOutput("M.ready",  64'(readyM), 64'(expReady));
        checkOutput("M.seqBit", 64'(seqM),   64'(expM));
        checkOutput("M.first",  64'(firstM), 64'(expFirst));
        checkOutput("M.done",   64'(doneM),  64'(expDone));
        checkOutput("M.level",  64'(levelM), 64'(mQueue.size()));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".L.ready"},  64'(readyL), 64'd0);
        checkOutput({tag, ".L.seqBit"}, 64'(seqL),   64'd0);
        checkOutput({tag, ".L.bitVld"}, 64'(bvL),    64'd0);
        checkOutput({tag, ".L.first"},  64'(firstL), 64'd0);
        checkOutput({tag, ".L.done"},   64'(doneL),  64'd0);
        checkOutput({tag, ".L.busy"},   64'(busyL),  64'd0);
        checkOutput({tag, ".L.level"},  64'(levelL), 64'd0);
        checkOutput({tag, ".M.busy"},   64'(busyM),  64'd0);
        checkOutput({tag, ".M.level"},  64'(levelM), 64'd0);
    endtask

    // One clock cycle: drive at the falling edge, advance the model at the
    // rising edge, compare at the next falling edge.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic c);
        iValid = v;
        iData  = d;
        iClr   = c;
        @(posedge clock);
        modelStep(v, d, c);
        @(negedge clock);
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, DATA_W'($urandom), 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstN   = 1'b0;
        iClr   = 1'b0;
        iValid = 1'b0;
        iData  = '0;
        modelReset();

        // Reset state, including o_ready held low while in reset.
        #12;
        checkAllZero("reset");
        @(negedge clock);
        rstN = 1'b1;

        // Single word, first-bit timing and idle afterwards.
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, 10'h2B5, 1'b0);
        idleCycles(14);

        // Back-to-back words on consecutive edges.
        applyStimulus(1'b1, 10'h3FF, 1'b0);
        applyStimulus(1'b1, 10'h000, 1'b0);
        applyStimulus(1'b1, 10'h155, 1'b0);
        idleCycles(34);

        // Hold valid so the FIFO fills and ready drops.
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, DATA_W'($urandom), 1'b0);
        idleCycles(60);

        // Clear on bit 4 of a frame with two words queued.
        applyStimulus(1'b1, DATA_W'($urandom), 1'b0);
        applyStimulus(1'b1, DATA_W'($urandom), 1'b0);
        applyStimulus(1'b1, DATA_W'($urandom), 1'b0);
        for (int i = 0; i < 40 && !(mBusy && mIdx == 4); i++) idleCycles(1);
        checkOutput("clr.reachedBit4", 64'(mBusy && mIdx == 4), 64'd1);
        applyStimulus(1'b1, DATA_W'($urandom), 1'b1);
        checkOutput("clr.level", 64'(levelL), 64'd0);
        checkOutput("clr.ready", 64'(readyL), 64'd1);
        applyStimulus(1'b1, 10'h001, 1'b0);
        idleCycles(14);

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), DATA_W'($urandom),
                          1'($urandom_range(0, 63) == 0));
        end

        // Asynchronous reset in the middle of a frame.
        applyStimulus(1'b1, DATA_W'($urandom), 1'b0);
        idleCycles(3);
        #2;
        rstN = 1'b0;
        #1;
        checkAllZero("asyncRst");
        modelReset();
        iValid = 1'b0;
        @(negedge clock);
        compareAll();
        rstN = 1'b1;
        applyStimulus(1'b1, 10'h2B5, 1'b0);
        applyStimulus(1'b1, 10'h2B5, 1'b0);
        idleCycles(14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
